laser_spot_locator: RTL and testbench

Consumes the per-pixel write stream from the camera capture stage and locates the laser spot in each captured frame. The stream is `pix_we`/`pix_din`/`hcount`/`vcount`, with `frame_start`/`frame_done` bracketing each frame. A pixel qualifies when it passes per-channel colour thresholds. The block accumulates the count and coordinate sums of qualifying pixels, divides them serially at end of frame, and publishes the centroid `(spot_x, spot_y)` to the projector/pinball logic.

---
 rtl/laser_spot_locator.sv | 200 ++++++++++++++++++++
 tb/tb_laser_spot_locator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_spot_locator.sv
// Laser spot centroid locator: accumulates qualifying red pixels over a frame,
// then divides the coordinate sums by the pixel count with a serial restoring divider.
module laser_spot_locator #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter logic [4:0]  R_THRESH   = 5'd24,
   parameter logic [4:0]  G_MAX      = 5'd8,
   parameter logic [4:0]  B_MAX      = 5'd8,
   parameter int unsigned MIN_PIXELS = 4
) (
   input  logic        camera_clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        pix_we,
   input  logic [15:0] pix_din,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        frame_done,
   output logic [9:0]  spot_x,
   output logic [9:0]  spot_y,
   output logic [18:0] spot_count,
   output logic        spot_found,
   output logic        spot_valid,
   output logic        busy
);

   // state   | meaning
   // IDLE    | waiting for frame_start, stream ignored
   // ACCUM   | summing qualifying pixels
   // DIV_X   | sum_x / cnt, one quotient bit per cycle
   // DIV_Y   | sum_y / cnt, one quotient bit per cycle
   // PUBLISH | spot_valid pulse, results visible
   typedef enum logic [2:0] {IDLE, ACCUM, DIV_X, DIV_Y, PUBLISH} state_t;

   localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
   localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
   localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);
   localparam logic [4:0]  DIV_LAST = 5'd27;

   state_t      state_q, state_d;
   logic [18:0] cnt_q, cnt_d;
   logic [27:0] sum_x_q, sum_x_d;
   logic [27:0] sum_y_q, sum_y_d;
   logic [19:0] rem_q, rem_d;
   logic [27:0] quo_q, quo_d;
   logic [4:0]  div_cnt_q, div_cnt_d;
   logic [9:0]  quo_x_q, quo_x_d;
   logic [9:0]  spot_x_q, spot_x_d;
   logic [9:0]  spot_y_q, spot_y_d;
   logic [18:0] spot_count_q, spot_count_d;
   logic        spot_found_q, spot_found_d;
   logic        spot_valid_q, spot_valid_d;
   logic        busy_q, busy_d;

   logic        pix_ok;
   logic [18:0] cnt_acc;
   logic [27:0] sum_x_acc, sum_y_acc;
   logic [19:0] rem_sh, rem_nx;
   logic [27:0] quo_nx;
   logic        rem_ge;
   logic        div_tc;
   logic        unused_pix_msb;

   assign unused_pix_msb = pix_din[15];

   assign pix_ok = pix_we
                 && ({1'b0, hcount} < H_LIM)
                 && ({1'b0, vcount} < V_LIM)
                 && (pix_din[14:10] >= R_THRESH)
                 && (pix_din[9:5]   <= G_MAX)
                 && (pix_din[4:0]   <= B_MAX);

   assign cnt_acc   = cnt_q + {18'd0, pix_ok};
   assign sum_x_acc = sum_x_q + (pix_ok ? {18'd0, hcount} : 28'd0);
   assign sum_y_acc = sum_y_q + (pix_ok ? {18'd0, vcount} : 28'd0);

   // The remainder never reaches cnt (< 2^19), so 20 bits hold the shifted trial value.
   assign rem_sh = {rem_q[18:0], quo_q[27]};
   assign rem_ge = rem_sh >= {1'b0, cnt_q};
   assign rem_nx = rem_ge ? (rem_sh - {1'b0, cnt_q}) : rem_sh;
   assign quo_nx = {quo_q[26:0], rem_ge};
   assign div_tc = (div_cnt_q == 5'd0);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sum_x_d      = sum_x_q;
      sum_y_d      = sum_y_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      div_cnt_d    = div_cnt_q;
      quo_x_d      = quo_x_q;
      spot_x_d     = spot_x_q;
      spot_y_d     = spot_y_q;
      spot_count_d = spot_count_q;
      spot_found_d = spot_found_q;
      spot_valid_d = 1'b0;

      if (frame_start) begin
         cnt_d   = '0;
         sum_x_d = '0;
         sum_y_d = '0;
         state_d = ACCUM;
      end else begin
         case (state_q)
            IDLE: ;
            ACCUM: begin
               cnt_d   = cnt_acc;
               sum_x_d = sum_x_acc;
               sum_y_d = sum_y_acc;
               if (frame_done) begin
                  if (cnt_acc < MIN_CNT) begin
                     state_d      = PUBLISH;
                     spot_valid_d = 1'b1;
                     spot_count_d = cnt_acc;
                     spot_found_d = 1'b0;
                  end else begin
                     state_d   = DIV_X;
                     quo_d     = sum_x_acc;
                     rem_d     = '0;
                     div_cnt_d = DIV_LAST;
                  end
               end
            end
            DIV_X: begin
               rem_d     = rem_nx;
               quo_d     = quo_nx;
               div_cnt_d = div_cnt_q - 5'd1;
               if (div_tc) begin
                  quo_x_d   = quo_nx[9:0];
                  quo_d     = sum_y_q;
                  rem_d     = '0;
                  div_cnt_d = DIV_LAST;
                  state_d   = DIV_Y;
               end
            end
            DIV_Y: begin
               rem_d     = rem_nx;
               quo_d     = quo_nx;
               div_cnt_d = div_cnt_q - 5'd1;
               if (div_tc) begin
                  state_d      = PUBLISH;
                  spot_valid_d = 1'b1;
                  spot_count_d = cnt_q;
                  spot_found_d = 1'b1;
                  spot_x_d     = quo_x_q;
                  spot_y_d     = quo_nx[9:0];
               end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d == ACCUM) || (state_d == DIV_X) || (state_d == DIV_Y);
   end

   // Results are loaded on PUBLISH entry so they are already visible during the pulse.
   always_ff @(posedge camera_clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sum_x_q      <= '0;
         sum_y_q      <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         div_cnt_q    <= '0;
         quo_x_q      <= '0;
         spot_x_q     <= '0;
         spot_y_q     <= '0;
         spot_count_q <= '0;
         spot_found_q <= 1'b0;
         spot_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sum_x_q      <= sum_x_d;
         sum_y_q      <= sum_y_d;
         rem_q        <= rem_d;
         quo_q        <= quo_d;
         div_cnt_q    <= div_cnt_d;
         quo_x_q      <= quo_x_d;
         spot_x_q     <= spot_x_d;
         spot_y_q     <= spot_y_d;
         spot_count_q <= spot_count_d;
         spot_found_q <= spot_found_d;
         spot_valid_q <= spot_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign spot_x     = spot_x_q;
   assign spot_y     = spot_y_q;
   assign spot_count = spot_count_q;
   assign spot_found = spot_found_q;
   assign spot_valid = spot_valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_laser_spot_locator.sv
// Directed bench for laser_spot_locator; a second, small-frame instance covers the full-frame case.
module tb_laser_spot_locator;

   localparam logic [15:0] RED = 16'h7C00;

   logic        camera_clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic        pix_we = 1'b0;
   logic [15:0] pix_din = '0;
   logic [9:0]  hcount = '0;
   logic [9:0]  vcount = '0;
   logic        frame_done = 1'b0;

   logic [9:0]  spot_x, spot_y, s_spot_x, s_spot_y;
   logic [18:0] spot_count, s_spot_count;
   logic        spot_found, spot_valid, busy;
   logic        s_spot_found, s_spot_valid, s_busy;

   int tests_run = 0;
   int tests_failed = 0;
   int valid_pulses = 0;

   laser_spot_locator dut (
      .camera_clk(camera_clk), .reset(reset), .frame_start(frame_start),
      .pix_we(pix_we), .pix_din(pix_din), .hcount(hcount), .vcount(vcount),
      .frame_done(frame_done), .spot_x(spot_x), .spot_y(spot_y),
      .spot_count(spot_count), .spot_found(spot_found),
      .spot_valid(spot_valid), .busy(busy)
   );

   laser_spot_locator #(.H_ACTIVE(64), .V_ACTIVE(48)) dut_s (
      .camera_clk(camera_clk), .reset(reset), .frame_start(frame_start),
      .pix_we(pix_we), .pix_din(pix_din), .hcount(hcount), .vcount(vcount),
      .frame_done(frame_done), .spot_x(s_spot_x), .spot_y(s_spot_y),
      .spot_count(s_spot_count), .spot_found(s_spot_found),
      .spot_valid(s_spot_valid), .busy(s_busy)
   );

   always #5 camera_clk = ~camera_clk;

   always @(negedge camera_clk) if (spot_valid === 1'b1) valid_pulses++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] px(input logic x, input logic [4:0] r, g, b);
      return {x, r, g, b};
   endfunction

   task automatic drive(input logic we, input logic [9:0] h, input logic [9:0] v,
                        input logic [15:0] d, input logic fs, input logic fd);
      @(negedge camera_clk);
      pix_we = we; hcount = h; vcount = v; pix_din = d;
      frame_start = fs; frame_done = fd;
      @(posedge camera_clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 10'd0, 10'd0, 16'h0000, 1'b0, 1'b0);
   endtask

   // lat = k means spot_valid is high in the cycle sampled by edge T+k (T = frame_done edge)
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge camera_clk);
         pix_we = 1'b0; frame_start = 1'b0; frame_done = 1'b0;
         if (spot_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      int p0;
      reset = 1'b1;
      idle(3);
      @(negedge camera_clk);
      reset = 1'b0;
      tests_run++;
      if ({spot_x, spot_y} !== 20'd0) begin
         $display("FAIL reset_xy: got %0d/%0d want 0/0", spot_x, spot_y); tests_failed++;
      end
      tests_run++;
      if (spot_count !== 19'd0 || spot_found !== 1'b0) begin
         $display("FAIL reset_count: got %0d found %0b want 0/0", spot_count, spot_found); tests_failed++;
      end
      tests_run++;
      if (spot_valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL reset_flags: got valid %0b busy %0b want 0/0", spot_valid, busy); tests_failed++;
      end
      p0 = valid_pulses;
      for (int i = 0; i < 100; i++)
         drive((i % 3) == 0, 10'(i), 10'(i), RED, 1'b0, (i % 7) == 0);
      @(negedge camera_clk);
      tests_run++;
      if (valid_pulses != p0) begin
         $display("FAIL idle_pulses: got %0d pulses want 0", valid_pulses - p0); tests_failed++;
      end
      tests_run++;
      if ({spot_x, spot_y, spot_count, spot_found, busy} !== '0) begin
         $display("FAIL idle_outputs: got x %0d y %0d cnt %0d found %0b busy %0b want all 0",
                  spot_x, spot_y, spot_count, spot_found, busy); tests_failed++;
      end
   endtask

   task automatic test_spot;
      int lat;
      drive(1'b0, 10'd0, 10'd0, 16'h0000, 1'b1, 1'b0);
      for (int h = 80; h < 120; h++) drive(1'b1, 10'(h), 10'd45, 16'h0000, 1'b0, 1'b0);
      #1;
      tests_run++;
      if (busy !== 1'b1) begin
         $display("FAIL busy_accum: got %0b want 1", busy); tests_failed++;
      end
      for (int k = 0; k < 9; k++)
         drive(1'b1, 10'(99 + k % 3), 10'(49 + k / 3), RED, 1'b0, k == 8);
      wait_valid(lat);
      tests_run++;
      if (lat != 57) begin
         $display("FAIL spot_latency: got %0d want 57", lat); tests_failed++;
      end
      tests_run++;
      if (spot_x !== 10'd100 || spot_y !== 10'd50) begin
         $display("FAIL spot_xy: got %0d/%0d want 100/50", spot_x, spot_y); tests_failed++;
      end
      tests_run++;
      if (spot_count !== 19'd9 || spot_found !== 1'b1) begin
         $display("FAIL spot_count: got %0d found %0b want 9/1", spot_count, spot_found); tests_failed++;
      end
      @(negedge camera_clk);
      tests_run++;
      if (spot_valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL spot_pulse_end: got valid %0b busy %0b want 0/0", spot_valid, busy); tests_failed++;
      end
   endtask

   task automatic test_no_spot;
      int lat;
      drive(1'b0, 10'd0, 10'd0, 16'h0000, 1'b1, 1'b0);
      drive(1'b1, 10'd300, 10'd200, RED, 1'b0, 1'b0);
      drive(1'b1, 10'd301, 10'd200, RED, 1'b0, 1'b0);
      drive(1'b0, 10'd0, 10'd0, 16'h0000, 1'b0, 1'b1);
      wait_valid(lat);
      tests_run++;
      if (lat != 1) begin
         $display("FAIL nospot_latency: got %0d want 1", lat); tests_failed++;
      end
      tests_run++;
      if (spot_found !== 1'b0 || spot_count !== 19'd2) begin
         $display("FAIL nospot_count: got %0d found %0b want 2/0", spot_count, spot_found); tests_failed++;
      end
      tests_run++;
      if (spot_x !== 10'd100 || spot_y !== 10'd50) begin
         $display("FAIL nospot_hold: got %0d/%0d want 100/50", spot_x, spot_y); tests_failed++;
      end
   endtask

   task automatic test_filters;
      int lat;
      drive(1'b0, 10'd0, 10'd0, 16'h0000, 1'b1, 1'b0);
      drive(1'b1, 10'd700, 10'd10, RED, 1'b0, 1'b0);
      drive(1'b1, 10'd640, 10'd10, RED, 1'b0, 1'b0);
      drive(1'b1, 10'd50, 10'd50, px(1'b0, 5'd31, 5'd20, 5'd0), 1'b0, 1'b0);
      drive(1'b1, 10'd60, 10'd60, px(1'b0, 5'd23, 5'd0, 5'd0), 1'b0, 1'b0);
      drive(1'b1, 10'd70, 10'd70, px(1'b0, 5'd31, 5'd0, 5'd9), 1'b0, 1'b0);
      drive(1'b1, 10'd80, 10'd480, RED, 1'b0, 1'b0);
      drive(1'b0, 10'd90, 10'd90, RED, 1'b0, 1'b0);
      drive(1'b1, 10'd10, 10'd10, RED, 1'b0, 1'b0);
      drive(1'b1, 10'd11, 10'd10, RED, 1'b0, 1'b0);
      drive(1'b1, 10'd10, 10'd11, RED, 1'b0, 1'b0);
      drive(1'b1, 10'd11, 10'd11, RED, 1'b0, 1'b1);
      wait_valid(lat);
      tests_run++;
      if (spot_count !== 19'd4 || spot_found !== 1'b1) begin
         $display("FAIL filter_count: got %0d found %0b want 4/1", spot_count, spot_found); tests_failed++;
      end
      tests_run++;
      if (spot_x !== 10'd10 || spot_y !== 10'd10) begin
         $display("FAIL filter_xy: got %0d/%0d want 10/10", spot_x, spot_y); tests_failed++;
      end
      // threshold-edge colours and an ignored bit 15 all qualify
      drive(1'b0, 10'd0, 10'd0, 16'h0000, 1'b1, 1'b0);
      drive(1'b1, 10'd30, 10'd40, px(1'b0, 5'd24, 5'd8, 5'd8), 1'b0, 1'b0);
      drive(1'b1, 10'd31, 10'd40, px(1'b1, 5'd24, 5'd8, 5'd8), 1'b0, 1'b0);
      drive(1'b1, 10'd639, 10'd479, px(1'b0, 5'd24, 5'd9, 5'd8), 1'b0, 1'b0);
      drive(1'b1, 10'd30, 10'd41, px(1'b0, 5'd24, 5'd8, 5'd8), 1'b0, 1'b0);
      drive(1'b1, 10'd33, 10'd43, px(1'b0, 5'd24, 5'd8, 5'd8), 1'b0, 1'b1);
      wait_valid(lat);
      tests_run++;
      if (lat != 57 || spot_count !== 19'd4) begin
         $display("FAIL edge_count: got lat %0d cnt %0d want 57/4", lat, spot_count); tests_failed++;
      end
      tests_run++;
      if (spot_x !== 10'd31 || spot_y !== 10'd41) begin
         $display("FAIL edge_xy: got %0d/%0d want 31/41", spot_x, spot_y); tests_failed++;
      end
   endtask

   task automatic test_full_frame;
      int lat;
      drive(1'b0, 10'd0, 10'd0, 16'h0000, 1'b1, 1'b0);
      for (int v = 0; v < 49; v++)
         for (int h = 0; h < 66; h++)
            drive(1'b1, 10'(h), 10'(v), RED, 1'b0, (v == 48) && (h == 65));
      wait_valid(lat);
      tests_run++;
      if (lat != 57 || s_spot_valid !== 1'b1) begin
         $display("FAIL full_latency: got lat %0d small_valid %0b want 57/1", lat, s_spot_valid);
         tests_failed++;
      end
      tests_run++;
      if (s_spot_count !== 19'd3072 || s_spot_x !== 10'd31 || s_spot_y !== 10'd23) begin
         $display("FAIL full_small: got cnt %0d x %0d y %0d want 3072/31/23",
                  s_spot_count, s_spot_x, s_spot_y); tests_failed++;
      end
      tests_run++;
      if (spot_count !== 19'd3234 || spot_x !== 10'd32 || spot_y !== 10'd24) begin
         $display("FAIL full_main: got cnt %0d x %0d y %0d want 3234/32/24",
                  spot_count, spot_x, spot_y); tests_failed++;
      end
   endtask

   task automatic test_abort;
      int lat;
      int p0;
      drive(1'b0, 10'd0, 10'd0, 16'h0000, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++)
         drive(1'b1, 10'(400 + k % 2), 10'(400 + k / 2), RED, 1'b0, k == 3);
      idle(9);
      p0 = valid_pulses;
      drive(1'b1, 10'd5, 10'd5, RED, 1'b1, 1'b0);
      drive(1'b1, 10'd6, 10'd5, RED, 1'b0, 1'b0);
      drive(1'b1, 10'd7, 10'd5, RED, 1'b0, 1'b0);
      drive(1'b1, 10'd8, 10'd5, RED, 1'b0, 1'b0);
      drive(1'b1, 10'd9, 10'd5, RED, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++)
         drive(1'b1, 10'(200 + k % 2), 10'(300 + k / 2), RED, 1'b0, k == 3);
      wait_valid(lat);
      tests_run++;
      if (lat != 57) begin
         $display("FAIL abort_latency: got %0d want 57", lat); tests_failed++;
      end
      tests_run++;
      if (spot_x !== 10'd200 || spot_y !== 10'd300 || spot_count !== 19'd4) begin
         $display("FAIL abort_result: got x %0d y %0d cnt %0d want 200/300/4",
                  spot_x, spot_y, spot_count); tests_failed++;
      end
      @(negedge camera_clk);
      tests_run++;
      if (valid_pulses - p0 != 1) begin
         $display("FAIL abort_pulses: got %0d want 1", valid_pulses - p0); tests_failed++;
      end
   endtask

   task automatic test_reset_mid;
      int p0;
      drive(1'b0, 10'd0, 10'd0, 16'h0000, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++)
         drive(1'b1, 10'(20 + k), 10'd20, RED, 1'b0, k == 3);
      idle(40);
      p0 = valid_pulses;
      @(negedge camera_clk);
      reset = 1'b1;
      @(posedge camera_clk);
      @(negedge camera_clk);
      reset = 1'b0;
      tests_run++;
      if ({spot_x, spot_y, spot_count, spot_found, spot_valid, busy} !== '0) begin
         $display("FAIL midreset_outputs: got x %0d y %0d cnt %0d found %0b valid %0b busy %0b want all 0",
                  spot_x, spot_y, spot_count, spot_found, spot_valid, busy); tests_failed++;
      end
      idle(70);
      @(negedge camera_clk);
      tests_run++;
      if (valid_pulses != p0 || spot_count !== 19'd0) begin
         $display("FAIL midreset_pulse: got %0d pulses cnt %0d want 0/0", valid_pulses - p0, spot_count);
         tests_failed++;
      end
   endtask

   initial begin
      test_reset;
      test_spot;
      test_no_spot;
      test_filters;
      test_full_frame;
      test_abort;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
